// File: rtl/write_merge_buffer.sv
// rtl/write_merge_buffer.sv - line-granular write-merging store buffer with read forwarding and in-order drain
// Optional feature macro: WB_READ_FWD_EN (byte forwarding; otherwise rhit_o is a line-conflict flag).
module write_merge_buffer #(
   parameter int DEPTH  = 8,
   parameter int LINE_W = 128,
   parameter int ADDR_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wreq_i,
   input  logic [ADDR_W-1:0]        waddr_i,
   input  logic [LINE_W-1:0]        wdata_i,
   input  logic [LINE_W/8-1:0]      wstrb_i,
   output logic                     wready_o,
   output logic                     whit_o,
   input  logic                     rreq_i,
   input  logic [ADDR_W-1:0]        raddr_i,
   output logic                     rhit_o,
   output logic [LINE_W-1:0]        rdata_o,
   output logic [LINE_W/8-1:0]      rstrb_o,
   output logic                     m_valid_o,
   input  logic                     m_ready_i,
   output logic [ADDR_W-1:0]        m_addr_o,
   output logic [LINE_W-1:0]        m_data_o,
   output logic [LINE_W/8-1:0]      m_strb_o,
   input  logic                     flush_i,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int SB  = LINE_W / 8;
   localparam int OFF = $clog2(SB);
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;

   typedef enum logic {IDLE, SEND} state_t;

   logic [ADDR_W-1:0] ent_addr [DEPTH];
   logic [LINE_W-1:0] ent_data [DEPTH];
   logic [SB-1:0]     ent_strb [DEPTH];
   logic [DEPTH-1:0]  ent_valid, valid_next;
   logic [PW-1:0]     head, tail, hidx, hit_idx;
   logic [CW-1:0]     count;
   logic              flush_q, flushing, hit, alloc, pop, full, empty;
   logic [ADDR_W-1:0] wline, rline;
   logic [LINE_W-1:0] wmask;
   logic              unused;
   state_t            state;

   function automatic logic [LINE_W-1:0] byte_mask(input logic [SB-1:0] s);
      for (int b = 0; b < SB; b++) byte_mask[b*8 +: 8] = {8{s[b]}};
   endfunction

   assign wline  = {waddr_i[ADDR_W-1:OFF], {OFF{1'b0}}};
   assign rline  = {raddr_i[ADDR_W-1:OFF], {OFF{1'b0}}};
   assign wmask  = byte_mask(wstrb_i);
   assign unused = ^{waddr_i[OFF-1:0], raddr_i[OFF-1:0]};

   // Age order walk from head+1 so the last match is the youngest; head is never a merge target.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      hidx    = '0;
      for (int k = 1; k < DEPTH; k++) begin
         hidx = head + PW'(k);
         if (ent_valid[hidx] && ent_addr[hidx] == wline) begin
            hit     = 1'b1;
            hit_idx = hidx;
         end
      end
   end

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign flushing = flush_q & ~empty;
   assign wready_o = rst & ~flushing & (hit | ~full);
   assign whit_o   = wreq_i & wready_o & hit;
   assign alloc    = wreq_i & wready_o & ~hit;
   assign pop      = m_valid_o & m_ready_i;
   assign empty_o  = empty;
   assign full_o   = full;
   assign count_o  = count;

   always_comb begin
      valid_next = ent_valid;
      if (pop)   valid_next[head] = 1'b0;
      if (alloc) valid_next[tail] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (whit_o) begin
         ent_data[hit_idx] <= (ent_data[hit_idx] & ~wmask) | (wdata_i & wmask);
         ent_strb[hit_idx] <= ent_strb[hit_idx] | wstrb_i;
      end
      if (alloc) begin
         ent_addr[tail] <= wline;
         ent_data[tail] <= wdata_i & wmask;
         ent_strb[tail] <= wstrb_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         ent_valid <= '0;
         flush_q   <= 1'b0;
         state     <= IDLE;
         m_valid_o <= 1'b0;
         m_addr_o  <= '0;
         m_data_o  <= '0;
         m_strb_o  <= '0;
      end else begin
         ent_valid <= valid_next;
         count     <= count + CW'(alloc) - CW'(pop);
         if (alloc) tail <= tail + 1'b1;
         if (flush_i)    flush_q <= 1'b1;
         else if (empty) flush_q <= 1'b0;
         case (state)
            IDLE: if (!empty) begin
               m_addr_o  <= ent_addr[head];
               m_data_o  <= ent_data[head];
               m_strb_o  <= ent_strb[head];
               m_valid_o <= 1'b1;
               state     <= SEND;
            end
            SEND: if (m_ready_i) begin
               m_valid_o <= 1'b0;
               head      <= head + 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WB_READ_FWD_EN
   logic [PW-1:0] ridx;

   always_comb begin
      rdata_o = '0;
      rstrb_o = '0;
      ridx    = '0;
      if (rst && rreq_i) begin
         for (int k = 0; k < DEPTH; k++) begin
            ridx = head + PW'(k);
            if (ent_valid[ridx] && ent_addr[ridx] == rline) begin
               for (int b = 0; b < SB; b++) begin
                  if (ent_strb[ridx][b]) begin
                     rdata_o[b*8 +: 8] = ent_data[ridx][b*8 +: 8];
                     rstrb_o[b]        = 1'b1;
                  end
               end
            end
         end
      end
   end

   assign rhit_o = rreq_i & |rstrb_o;
`else
   logic rmatch;

   always_comb begin
      rmatch = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (ent_valid[i] && ent_addr[i] == rline) rmatch = 1'b1;
   end

   assign rdata_o = '0;
   assign rstrb_o = '0;
   assign rhit_o  = rst & rreq_i & rmatch;
`endif
endmodule

// File: tb/tb_write_merge_buffer.sv
// tb/tb_write_merge_buffer.sv - directed and randomized check of write_merge_buffer against a queue model
module tb_write_merge_buffer;
   localparam int DEPTH = 8;
   localparam int SB    = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wreq = 1'b0, rreq = 1'b0, m_ready = 1'b0, flush = 1'b0;
   logic [31:0]   waddr = '0, raddr = '0;
   logic [127:0]  wdata = '0;
   logic [15:0]   wstrb = '0;
   logic          wready_o, whit_o, rhit_o, m_valid_o, empty_o, full_o;
   logic [127:0]  rdata_o, m_data_o;
   logic [15:0]   rstrb_o, m_strb_o;
   logic [31:0]   m_addr_o;
   logic [3:0]    count_o;

   write_merge_buffer #(.DEPTH(DEPTH), .LINE_W(128), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .wreq_i(wreq), .waddr_i(waddr), .wdata_i(wdata), .wstrb_i(wstrb),
      .wready_o(wready_o), .whit_o(whit_o),
      .rreq_i(rreq), .raddr_i(raddr), .rhit_o(rhit_o), .rdata_o(rdata_o), .rstrb_o(rstrb_o),
      .m_valid_o(m_valid_o), .m_ready_i(m_ready), .m_addr_o(m_addr_o),
      .m_data_o(m_data_o), .m_strb_o(m_strb_o),
      .flush_i(flush), .empty_o(empty_o), .full_o(full_o), .count_o(count_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]  addr;
      logic [127:0] data;
      logic [15:0]  strb;
   } ent_t;

   ent_t q[$];
   bit   sending = 0, flag = 0;
   int   vectors = 0, miscompares = 0, hs = 0;
   int   p_hi;
   bit   p_wready;
   logic s_whit, s_wready, s_rhit, s_empty;
   logic [127:0] s_rdata;
   logic [15:0]  s_rstrb;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] mask(input logic [15:0] s);
      logic [127:0] m;
      for (int b = 0; b < SB; b++) m[b*8 +: 8] = s[b] ? 8'hFF : 8'h00;
      return m;
   endfunction

   function automatic logic [31:0] line_of(input logic [31:0] a);
      return a & 32'hFFFF_FFF0;
   endfunction

   // Youngest buffered entry for this line, excluding the oldest (head), or -1.
   function automatic int find_hit(input logic [31:0] ln);
      for (int i = q.size() - 1; i >= 1; i--)
         if (q[i].addr == ln) return i;
      return -1;
   endfunction

   task automatic model_check();
      logic [127:0] fd;
      logic [15:0]  fs;
      bit           any;
      int           hi;
      hi = find_hit(line_of(waddr));
      p_hi = hi;
      p_wready = rst && !(flag && q.size() != 0) && (hi > 0 || q.size() < DEPTH);
      fd = '0; fs = '0; any = 0;
      foreach (q[i]) begin
         if (q[i].addr == line_of(raddr)) begin
            any = 1;
            for (int b = 0; b < SB; b++)
               if (q[i].strb[b]) begin
                  fd[b*8 +: 8] = q[i].data[b*8 +: 8];
                  fs[b] = 1'b1;
               end
         end
      end
      s_whit = whit_o; s_wready = wready_o; s_rhit = rhit_o;
      s_rdata = rdata_o; s_rstrb = rstrb_o; s_empty = empty_o;
      if (m_valid_o === 1'b1 && m_ready === 1'b1) hs++;
      chk("wready", wready_o, p_wready);
      chk("whit", whit_o, wreq && p_wready && hi > 0);
`ifdef WB_READ_FWD_EN
      chk("rhit", rhit_o, rst && rreq && fs != 0);
      chk("rdata", rdata_o, (rst && rreq) ? fd : 128'h0);
      chk("rstrb", rstrb_o, (rst && rreq) ? fs : 16'h0);
`else
      chk("rhit", rhit_o, rst && rreq && any);
      chk("rdata", rdata_o, 128'h0);
      chk("rstrb", rstrb_o, 16'h0);
`endif
      chk("count", count_o, q.size());
      chk("empty", empty_o, q.size() == 0);
      chk("full", full_o, q.size() == DEPTH);
      chk("m_valid", m_valid_o, sending);
      if (sending) begin
         chk("m_addr", m_addr_o, q[0].addr);
         chk("m_data", m_data_o, q[0].data);
         chk("m_strb", m_strb_o, q[0].strb);
      end
   endtask

   task automatic model_update();
      ent_t e;
      bit   was_empty;
      if (!rst) begin
         q.delete(); sending = 0; flag = 0;
      end else begin
         was_empty = (q.size() == 0);
         if (wreq && p_wready) begin
            if (p_hi > 0) begin
               e = q[p_hi];
               e.data = (e.data & ~mask(wstrb)) | (wdata & mask(wstrb));
               e.strb = e.strb | wstrb;
               q[p_hi] = e;
            end else begin
               e.addr = line_of(waddr);
               e.data = wdata & mask(wstrb);
               e.strb = wstrb;
               q.push_back(e);
            end
         end
         if (sending && m_ready) begin
            void'(q.pop_front());
            sending = 0;
         end else if (!sending && !was_empty) begin
            sending = 1;
         end
         if (flush) flag = 1;
         else if (was_empty) flag = 0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s);
      wreq = 1'b1; waddr = a; wdata = d; wstrb = s;
      tick();
      wreq = 1'b0;
   endtask

   task automatic drain_all();
      int n = 0;
      m_ready = 1'b1;
      while (empty_o !== 1'b1 && n < 100) begin tick(); n++; end
      chk("drain_bound", n < 100, 1'b1);
      m_ready = 1'b0;
      tick();
   endtask

   logic [127:0] d1, d2, exp_d;
   int           n;

   initial begin
      d1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
      d2 = 128'hF0E0D0C0_B0A09080_70605040_30201000;
      @(posedge clk);
      #1;
      tick();
      chk("rst_empty", empty_o, 1'b1);
      chk("rst_count", count_o, 4'd0);
      chk("rst_mvalid", m_valid_o, 1'b0);
      chk("rst_wready", s_wready, 1'b0);
      rst = 1'b1;
      tick();

      // Store-to-drain latency
      m_ready = 1'b1;
      store(32'h1000, d1, 16'hFFFF);
      chk("lat_count1", count_o, 4'd1);
      chk("lat_mvalid_t", m_valid_o, 1'b0);
      tick();
      chk("lat_mvalid_t1", m_valid_o, 1'b1);
      chk("lat_maddr", m_addr_o, 32'h1000);
      tick();
      tick();
      chk("lat_count0", count_o, 4'd0);
      chk("lat_empty", empty_o, 1'b1);

      // Merge into a non-head entry
      m_ready = 1'b0;
      store(32'h2000, d1, 16'hFFFF);
      store(32'h3000, d1, 16'h000F);
      store(32'h3004, d2, 16'h00F0);
      chk("merge_whit", s_whit, 1'b1);
      chk("merge_count", count_o, 4'd2);
      m_ready = 1'b1;
      n = 0;
      while (!(m_valid_o === 1'b1 && m_addr_o === 32'h3000) && n < 20) begin tick(); n++; end
      chk("merge_wait", n < 20, 1'b1);
      exp_d = (d1 & mask(16'h000F)) | (d2 & mask(16'h00F0));
      chk("merge_mstrb", m_strb_o, 16'h00FF);
      chk("merge_mdata", m_data_o, exp_d);
      drain_all();

      // Head is locked against merging
      store(32'h2000, d1, 16'hFFFF);
      tick();
      tick();
      chk("lock_head_valid", m_valid_o, 1'b1);
      store(32'h2000, d2, 16'hFFFF);
      chk("lock_whit", s_whit, 1'b0);
      chk("lock_count", count_o, 4'd2);
      chk("lock_mdata", m_data_o, d1);

      // Fill to DEPTH, refuse a 9th line, still accept a merge
      for (int i = 0; i < 6; i++) store(32'h5000 + i * 32'h1000, d2 ^ i, 16'hFFFF);
      chk("fill_full", full_o, 1'b1);
      store(32'hB000, d1, 16'hFFFF);
      chk("full_refuse", s_wready, 1'b0);
      store(32'h5000, d1, 16'h0003);
      chk("full_merge_whit", s_whit, 1'b1);
      chk("full_merge_wready", s_wready, 1'b1);
      m_ready = 1'b1;
      store(32'hB000, d1, 16'hFFFF);
      chk("full_pop_refuse", s_wready, 1'b0);
      m_ready = 1'b0;
      drain_all();

      // Forwarding / conflict probe
      store(32'h4000, 128'hAABBCCDD, 16'h000F);
      rreq = 1'b1; raddr = 32'h4008;
      tick();
      chk("fwd_rhit", s_rhit, 1'b1);
`ifdef WB_READ_FWD_EN
      chk("fwd_rstrb", s_rstrb, 16'h000F);
      chk("fwd_rdata", s_rdata[31:0], 32'hAABBCCDD);
`else
      chk("fwd_rdata", s_rdata, 128'h0);
      chk("fwd_rstrb", s_rstrb, 16'h0);
`endif
      raddr = 32'h4010;
      tick();
      chk("fwd_miss", s_rhit, 1'b0);
      rreq = 1'b0;
      drain_all();

      // Flush with three entries buffered
      store(32'h6000, d1, 16'hFFFF);
      store(32'h7000, d1, 16'hFFFF);
      store(32'h8000, d1, 16'hFFFF);
      hs = 0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      m_ready = 1'b1;
      wreq = 1'b1; waddr = 32'hD000; wdata = d2; wstrb = 16'hFFFF;
      n = 0;
      while (n < 50) begin
         tick();
         n++;
         if (s_empty === 1'b1) break;
         chk("flush_wready", s_wready, 1'b0);
      end
      wreq = 1'b0;
      chk("flush_bound", n < 50, 1'b1);
      chk("flush_handshakes", hs, 3);
      drain_all();

      // Reset taken mid-SEND
      store(32'hC000, d1, 16'hFFFF);
      tick();
      chk("rst_send_pre", m_valid_o, 1'b1);
      rst = 1'b0;
      tick();
      chk("rst_send_mvalid", m_valid_o, 1'b0);
      chk("rst_send_count", count_o, 4'd0);
      rst = 1'b1;
      tick();

      // Randomized traffic over a small line pool
      for (int c = 0; c < 1500; c++) begin
         wreq    = ($urandom_range(0, 9) < 6);
         waddr   = 32'h8000 + $urandom_range(0, 5) * 32'h10 + $urandom_range(0, 15);
         wdata   = {$urandom, $urandom, $urandom, $urandom};
         wstrb   = 16'($urandom);
         m_ready = $urandom_range(0, 1);
         rreq    = $urandom_range(0, 1);
         raddr   = 32'h8000 + $urandom_range(0, 6) * 32'h10 + $urandom_range(0, 15);
         flush   = ($urandom_range(0, 49) == 0);
         rst     = ($urandom_range(0, 199) != 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
